bin2bcd_display: RTL and testbench

Sequential binary-to-BCD converter between the calculator datapath and the VGA renderer. It takes a signed two's-complement result plus an operator code and an error flag. It produces the four BCD digits, sign, operator and NaN flag that the `vga` renderer draws as seven-segment glyphs. Conversion is iterative double-dabble (shift-add-3) under a start/done handshake. Display outputs are registered and held stable between conversions, so the renderer never sees a partial result.

---
 rtl/bin2bcd_display.sv | 156 +++++++++++++++
 tb/tb_bin2bcd_display.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_display.sv
// Iterative double-dabble converter feeding the seven-segment VGA renderer.
// Display outputs are registered and only change in FINISH, so the renderer never sees partial digits.
module bin2bcd_display #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             div_zero,
  input  logic [3:0]       op_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       num3,
  output logic [3:0]       num2,
  output logic [3:0]       num1,
  output logic [3:0]       num0,
  output logic             posneg,
  output logic [3:0]       op,
  output logic             is_nan
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABS,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_MAG = WIDTH'(9999);
  localparam logic [3:0]      OP_NONE = 4'd5;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_value;
  logic             r_div_zero;
  logic [3:0]       r_op_in;
  logic             r_neg;
  logic             r_err;
  logic [WIDTH-1:0] r_mag;
  logic [15:0]      r_bcd;
  logic [CW-1:0]    r_cnt;

  logic             w_neg;
  logic [WIDTH-1:0] w_mag;
  logic             w_err;
  logic [15:0]      w_bcd_adj;
  logic             w_last;

  // Magnitude of the captured operand; -2^(WIDTH-1) negates to itself, which read unsigned is correct.
  always_comb begin
    w_neg = r_value[WIDTH-1];
    w_mag = w_neg ? ('0 - r_value) : r_value;
    w_err = r_div_zero || (w_mag > MAX_MAG);
  end

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_last = (r_cnt == CW'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ABS;
      S_ABS:    w_next = w_err ? S_FINISH : S_SHIFT;
      S_SHIFT:  if (w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value    <= '0;
      r_div_zero <= 1'b0;
      r_op_in    <= OP_NONE;
      r_neg      <= 1'b0;
      r_err      <= 1'b0;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      done       <= 1'b0;
      num3       <= 4'd0;
      num2       <= 4'd0;
      num1       <= 4'd0;
      num0       <= 4'd0;
      posneg     <= 1'b0;
      op         <= OP_NONE;
      is_nan     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_value    <= value;
            r_div_zero <= div_zero;
            r_op_in    <= op_in;
          end
        end
        S_ABS: begin
          r_neg <= w_neg;
          r_err <= w_err;
          r_bcd <= '0;
          r_mag <= w_mag;
          r_cnt <= CW'(WIDTH);
        end
        S_SHIFT: begin
          {r_bcd, r_mag} <= {w_bcd_adj[14:0], r_mag, 1'b0};
          r_cnt          <= r_cnt - 1'b1;
        end
        S_FINISH: begin
          done <= 1'b1;
          op   <= r_op_in;
          if (r_err) begin
            num3   <= 4'd0;
            num2   <= 4'd0;
            num1   <= 4'd0;
            num0   <= 4'd0;
            posneg <= 1'b0;
            is_nan <= 1'b1;
          end else begin
            num3   <= r_bcd[15:12];
            num2   <= r_bcd[11:8];
            num1   <= r_bcd[7:4];
            num0   <= r_bcd[3:0];
            posneg <= r_neg;
            is_nan <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench for bin2bcd_display: stimulus pushes expected displays, a monitor checks each done pulse.
module tb_bin2bcd_display;

  localparam int WIDTH = 16;
  localparam int LAT_OK = WIDTH + 2;
  localparam int LAT_ERR = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             div_zero = 1'b0;
  logic [3:0]       op_in = 4'd5;
  logic             busy, done, posneg, is_nan;
  logic [3:0]       num3, num2, num1, num0, op;

  bin2bcd_display #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .div_zero(div_zero), .op_in(op_in), .busy(busy), .done(done),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0),
    .posneg(posneg), .op(op), .is_nan(is_nan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] n3, n2, n1, n0;
    logic       pn, nan;
    logic [3:0] op;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("num3", num3, e.n3);
        check("num2", num2, e.n2);
        check("num1", num1, e.n1);
        check("num0", num0, e.n0);
        check("posneg", posneg, e.pn);
        check("is_nan", is_nan, e.nan);
        check("op", op, e.op);
        check("busy_in_done", busy, 0);
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] n3, n2, n1, n0, input logic pn, nan,
                              input logic [3:0] o, input int due);
    exp_t e;
    e.n3 = n3; e.n2 = n2; e.n1 = n1; e.n0 = n0;
    e.pn = pn; e.nan = nan; e.op = o; e.due = due;
    return e;
  endfunction

  // One-cycle start pulse; the expected display is queued with its due cycle.
  task automatic conv(input logic [WIDTH-1:0] v, input logic dz, input logic [3:0] o,
                      input logic [3:0] n3, n2, n1, n0, input logic pn, nan);
    @(negedge clk);
    start = 1'b1; value = v; div_zero = dz; op_in = o;
    sb.push_back(mk(n3, n2, n1, n0, pn, nan, o, cyc + 1 + (nan ? LAT_ERR : LAT_OK)));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_num3"}, num3, 0);
    check({tag, "_num2"}, num2, 0);
    check({tag, "_num1"}, num1, 0);
    check({tag, "_num0"}, num0, 0);
    check({tag, "_posneg"}, posneg, 0);
    check({tag, "_is_nan"}, is_nan, 0);
    check({tag, "_op"}, op, 5);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");

    conv(16'd1234, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
    drain("d_1234", 40);
    conv(16'hD8F1, 1'b0, 4'd1, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0);
    drain("d_m9999", 40);
    conv(16'd0, 1'b0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    drain("d_zero", 40);
    conv(16'hFFFF, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    drain("d_m1", 40);
    conv(16'd10000, 1'b0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    drain("d_10000", 40);
    conv(16'h8000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    drain("d_m32768", 40);
    conv(16'd5, 1'b1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    drain("d_divzero", 40);

    // A second start mid-conversion must be ignored entirely.
    d0 = done_cnt;
    conv(16'd42, 1'b0, 4'd5, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; value = 16'd77; op_in = 4'd1;
    @(negedge clk);
    start = 1'b0;
    drain("d_ignore", 40);
    repeat (25) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 1);
    check("hold_num1", num1, 4);
    check("hold_num0", num0, 2);

    // start held high: done every WIDTH+3 cycles.
    @(negedge clk);
    start = 1'b1; value = 16'd9876; div_zero = 1'b0; op_in = 4'd3;
    for (int i = 0; i < 3; i++)
      sb.push_back(mk(4'd9, 4'd8, 4'd7, 4'd6, 1'b0, 1'b0, 4'd3, cyc + 1 + LAT_OK + i * (LAT_OK + 1)));
    drain("d_held", 120);
    start = 1'b0;
    repeat (25) @(negedge clk);

    // Reset mid-conversion aborts without a done pulse.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; value = 16'd4321; op_in = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    conv(16'd808, 1'b0, 4'd1, 4'd0, 4'd8, 4'd0, 4'd8, 1'b0, 1'b0);
    drain("d_808", 40);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
